config_rd_req_splitter: RTL and testbench
=========================================

Name: config_rd_req_splitter

Overview:
- Sits between the configuration read controller and the PCIe TX request engine in the i_pcie_clk domain.
- Accepts one configuration read request of up to 4096 bytes (address plus length) and splits it into memory-read sub-requests.
- Each sub-request is bounded by MAX_RD_REQ and never crosses a MAX_RD_REQ-aligned boundary, so it never crosses a 4 KB boundary.
- Throttles issue against a completion-byte credit pool, decremented by returning completions that carry the requester's tag.

Parameters:
MAX_RD_REQ, 512, max read request size in bytes; power of 2, 128..4096.
CPL_CREDIT_BYTES, 2048, max outstanding (requested but not yet completed) bytes; ≥ MAX_RD_REQ.

Ports:
i_pcie_clk  in  1  clock.
i_rst  in  1  synchronous active-high reset.
i_rd_req  in  1  level request from the controller; held until ack.
i_rd_req_addr  in  32  byte start address.
i_rd_req_len  in  12  byte length; 0 means 4096.
i_rd_req_tag  in  8  tag to stamp on all sub-requests; controller drives 0.
o_rd_req_ack  out  1  one-cycle pulse when the last sub-request is accepted downstream.
o_tlp_req  out  1  sub-request valid.
o_tlp_addr  out  32  sub-request byte address, bits [1:0] = 0.
o_tlp_len_dw  out  10  sub-request length in DW, 1..MAX_RD_REQ/4.
o_tlp_tag  out  8  = latched i_rd_req_tag.
i_tlp_ack  in  1  TX engine accepted the current sub-request.
i_cpl_valid  in  1  completion data beat.
i_cpl_tag  in  8  completion tag.
i_cpl_len_dw  in  3  DW carried in this beat: 0..2, since a 64-bit beat holds at most 2 DW.
o_outstanding  out  13  outstanding bytes, 0..4096+.
o_cpl_err  out  1  sticky; completion bytes exceeded outstanding.

Behaviour:
- Clock and reset: one clock, i_pcie_clk. Reset i_rst is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; outstanding 0; o_cpl_err 0.
- Address and length alignment: addr[1:0] and len[1:0] are treated as 0 (DW granular). len 0 is expanded to 4096 (13-bit remaining counter).
- State IDLE:
  - On i_rd_req=1, latch addr, remaining and tag, then go to CALC.
  - If len is 1..3 bytes (DW length 0), pulse ack immediately and go to WAIT_LOW with no TLP.
- State CALC (one cycle):
  - chunk = min(remaining, MAX_RD_REQ − (addr mod MAX_RD_REQ)).
  - If outstanding + chunk ≤ CPL_CREDIT_BYTES, go to ISSUE (o_tlp_req=1 next cycle). Otherwise stay in CALC.
- State ISSUE:
  - Hold o_tlp_req, o_tlp_addr and o_tlp_len_dw stable until i_tlp_ack.
  - On ack: o_tlp_req=0, addr += chunk, remaining −= chunk, outstanding += chunk.
  - If the new remaining is 0: o_rd_req_ack=1 for exactly one cycle, go to WAIT_LOW. Otherwise go to CALC.
  - i_tlp_ack is accepted in the same cycle o_tlp_req first rises (zero-wait).
- State WAIT_LOW:
  - Stay until i_rd_req=0, then go to IDLE. This guarantees a still-high level request is never re-accepted.
  - Minimum request-to-first-TLP latency: 2 cycles (IDLE→CALC→ISSUE).
- Credit accounting:
  - On i_cpl_valid && i_cpl_tag==latched tag: outstanding −= 4·i_cpl_len_dw.
  - Completions with other tags are ignored.
  - A same-cycle TLP ack and completion apply both (net update).
  - If the decrement would go below 0: clamp to 0 and set o_cpl_err; it clears only on reset.
- Completions keep being counted in every state, including IDLE, across back-to-back requests.
- Reset mid-operation: returns to IDLE at once, drops o_tlp_req in the same clock edge, and clears outstanding. Completions already in flight after reset may then set o_cpl_err; this is accepted.
- i_rd_req dropping before ack: it is ignored; the current request completes.

Decomposition:
- Shared package config_dma_pkg holds:
  - state enum (IDLE, CALC, ISSUE, WAIT_LOW);
  - DW_BYTES=4 and MAX_CFG_REQ_BYTES=4096;
  - the cfg_tag_t width.
- Natural sub-module cpl_credit_counter: outstanding-bytes up/down counter with clamp and sticky error, also reusable by the user DMA path.

Test Plan:
1. Aligned full request: addr=0x1000_0000, len=0, MAX_RD_REQ=512, immediate tlp_ack, completions returned promptly → 8 TLPs at 0x…000, 0x…200 … 0x…E00, each len_dw=128; a single ack pulse after the 8th; final outstanding matches the completions returned.
2. Unaligned start: addr=0x1000_0F80, len=0x100 → TLPs at 0x…0F80 (len_dw=32) and 0x…1000 (len_dw=32); no 4 KB crossing; one ack.
3. Credit stall: CPL_CREDIT_BYTES=1024, no completions, len=0 → exactly 2 TLPs issued, then o_tlp_req stays 0. Returning 64 beats of 2 DW (512 B) releases the 3rd TLP.
4. Simultaneous events: tlp_ack of 512 B and a cpl beat of 2 DW in the same cycle → outstanding changes by +504. A foreign-tag completion leaves it unchanged.
5. Level handshake: i_rd_req held high 10 cycles after ack → no second transfer until it goes low. A new request with len=4 gives one TLP, len_dw=1.
6. Reset mid-ISSUE with o_tlp_req=1 → next cycle o_tlp_req=0, outstanding=0, state IDLE. A subsequent cpl beat of 2 DW → o_cpl_err=1, outstanding stays 0.

Source files
------------

// File: rtl/config_dma_pkg.sv
// Shared types and constants for the configuration-read DMA path.
// Holds the splitter FSM state encoding, DW/request size constants,
// the tag type and the TLP sub-request payload struct.
package config_dma_pkg;

    localparam int unsigned DW_BYTES          = 4;
    localparam int unsigned MAX_CFG_REQ_BYTES = 4096;

    localparam int unsigned CFG_TAG_W    = 8;
    localparam int unsigned CFG_ADDR_W   = 32;
    localparam int unsigned CFG_LEN_W    = 12;
    // Remaining/outstanding byte counters must hold 4096, hence one bit over CFG_LEN_W.
    localparam int unsigned CFG_REM_W    = 13;
    localparam int unsigned TLP_LEN_DW_W = 10;
    localparam int unsigned CPL_LEN_DW_W = 3;

    typedef logic [CFG_TAG_W-1:0] cfg_tag_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CALC     = 2'd1,
        ISSUE    = 2'd2,
        WAIT_LOW = 2'd3
    } cfg_state_e;

    // Memory-read sub-request presented to the TX request engine.
    typedef struct packed {
        logic [CFG_ADDR_W-1:0]   addr;
        logic [TLP_LEN_DW_W-1:0] len_dw;
        cfg_tag_t                tag;
    } cfg_tlp_req_t;

endpackage

// File: rtl/cpl_credit_counter.sv
// Outstanding-bytes up/down counter for completion credit tracking.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   inc_en, inc_bytes    - bytes added when a read request is accepted
//   dec_en, dec_bytes    - bytes removed when completion data returns
//   count                - registered outstanding byte count
//   err                  - sticky flag: a decrement exceeded the count (clamped to 0)
module cpl_credit_counter #(
    parameter int unsigned CNT_W = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en,
    input  logic [CNT_W-1:0] inc_bytes,
    input  logic             dec_en,
    input  logic [CNT_W-1:0] dec_bytes,
    output logic [CNT_W-1:0] count,
    output logic             err
);

    localparam int unsigned SUM_W = CNT_W + 1;

    logic [SUM_W-1:0] sum_c;
    logic [SUM_W-1:0] dec_c;
    logic             underflow_c;

    // Net update: increment and decrement landing in the same cycle both apply.
    always_comb begin
        sum_c       = SUM_W'(count) + (inc_en ? SUM_W'(inc_bytes) : '0);
        dec_c       = dec_en ? SUM_W'(dec_bytes) : '0;
        underflow_c = (sum_c < dec_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            err   <= 1'b0;
        end else if (underflow_c) begin
            count <= '0;
            err   <= 1'b1;
        end else begin
            count <= CNT_W'(sum_c - dec_c);
        end
    end

endmodule

// File: rtl/config_rd_req_splitter.sv
// Splits one configuration read request (up to 4096 bytes) into memory-read
// sub-requests that never exceed or cross a MAX_RD_REQ-aligned boundary,
// throttled by a completion-byte credit pool.
// Ports:
//   i_pcie_clk, i_rst                     - clock, synchronous active-high reset
//   i_rd_req/_addr/_len/_tag, o_rd_req_ack - level request from the controller, ack pulse at end
//   o_tlp_req/_addr/_len_dw/_tag, i_tlp_ack - sub-request handshake to the TX engine
//   i_cpl_valid/_tag/_len_dw               - completion data beats returning credit
//   o_outstanding, o_cpl_err               - outstanding bytes, sticky credit underflow flag
module config_rd_req_splitter
    import config_dma_pkg::*;
#(
    parameter int unsigned MAX_RD_REQ       = 512,
    parameter int unsigned CPL_CREDIT_BYTES = 2048
) (
    input  logic                    i_pcie_clk,
    input  logic                    i_rst,
    input  logic                    i_rd_req,
    input  logic [CFG_ADDR_W-1:0]   i_rd_req_addr,
    input  logic [CFG_LEN_W-1:0]    i_rd_req_len,
    input  logic [CFG_TAG_W-1:0]    i_rd_req_tag,
    output logic                    o_rd_req_ack,
    output logic                    o_tlp_req,
    output logic [CFG_ADDR_W-1:0]   o_tlp_addr,
    output logic [TLP_LEN_DW_W-1:0] o_tlp_len_dw,
    output logic [CFG_TAG_W-1:0]    o_tlp_tag,
    input  logic                    i_tlp_ack,
    input  logic                    i_cpl_valid,
    input  logic [CFG_TAG_W-1:0]    i_cpl_tag,
    input  logic [CPL_LEN_DW_W-1:0] i_cpl_len_dw,
    output logic [CFG_REM_W-1:0]    o_outstanding,
    output logic                    o_cpl_err
);

    localparam int unsigned OFF_W = $clog2(MAX_RD_REQ);
    localparam int unsigned SUM_W = CFG_REM_W + 1;

    cfg_state_e state_q, state_d;

    logic [CFG_ADDR_W-1:0] addr_q;
    logic [CFG_REM_W-1:0]  rem_q;
    logic [CFG_REM_W-1:0]  chunk_q;
    cfg_tag_t              tag_q;
    logic                  ack_q;

    logic [CFG_REM_W-1:0]  req_bytes_c;
    logic                  short_c;
    logic [CFG_REM_W-1:0]  room_c;
    logic [CFG_REM_W-1:0]  chunk_c;
    logic [SUM_W-1:0]      credit_sum_c;
    logic                  fits_c;
    logic                  last_c;
    logic                  tlp_accept_c;
    logic                  cpl_match_c;
    cfg_tlp_req_t          tlp_c;

    // Request decode: DW-granular length, 0 means a full 4 KB.
    always_comb begin
        req_bytes_c = (i_rd_req_len == '0) ? CFG_REM_W'(MAX_CFG_REQ_BYTES)
                                           : CFG_REM_W'({i_rd_req_len[CFG_LEN_W-1:2], 2'b00});
        short_c     = (i_rd_req_len != '0) && (i_rd_req_len[CFG_LEN_W-1:2] == '0);
    end

    // Chunk is clipped to the next MAX_RD_REQ-aligned boundary.
    always_comb begin
        room_c       = CFG_REM_W'(MAX_RD_REQ) - CFG_REM_W'(addr_q[OFF_W-1:0]);
        chunk_c      = (rem_q < room_c) ? rem_q : room_c;
        credit_sum_c = SUM_W'(o_outstanding) + SUM_W'(chunk_c);
        fits_c       = (credit_sum_c <= SUM_W'(CPL_CREDIT_BYTES));
        last_c       = (rem_q == chunk_q);
        tlp_accept_c = (state_q == ISSUE) && i_tlp_ack;
        cpl_match_c  = i_cpl_valid && (i_cpl_tag == tag_q);
    end

    // State register.
    always_ff @(posedge i_pcie_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (i_rd_req)  state_d = short_c ? WAIT_LOW : CALC;
            CALC:     if (fits_c)    state_d = ISSUE;
            ISSUE:    if (i_tlp_ack) state_d = last_c ? WAIT_LOW : CALC;
            WAIT_LOW: if (!i_rd_req) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Request datapath: latched address, remaining bytes, chunk, tag and ack pulse.
    always_ff @(posedge i_pcie_clk) begin
        if (i_rst) begin
            addr_q  <= '0;
            rem_q   <= '0;
            chunk_q <= '0;
            tag_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_rd_req) begin
                        addr_q <= i_rd_req_addr & ~CFG_ADDR_W'(DW_BYTES - 1);
                        rem_q  <= req_bytes_c;
                        tag_q  <= i_rd_req_tag;
                        ack_q  <= short_c;
                    end
                end
                CALC: begin
                    chunk_q <= chunk_c;
                end
                ISSUE: begin
                    if (i_tlp_ack) begin
                        addr_q <= addr_q + CFG_ADDR_W'(chunk_q);
                        rem_q  <= rem_q - chunk_q;
                        ack_q  <= last_c;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from registered state and datapath.
    always_comb begin
        tlp_c        = '0;
        tlp_c.addr   = addr_q;
        // A 4096-byte chunk encodes as len_dw 0 (1024 DW), matching TLP length encoding.
        tlp_c.len_dw = chunk_q[TLP_LEN_DW_W+1:2];
        tlp_c.tag    = tag_q;

        o_tlp_req    = (state_q == ISSUE);
        o_tlp_addr   = tlp_c.addr;
        o_tlp_len_dw = tlp_c.len_dw;
        o_tlp_tag    = tlp_c.tag;
        o_rd_req_ack = ack_q;
    end

    cpl_credit_counter #(
        .CNT_W (CFG_REM_W)
    ) u_cpl_credit_counter (
        .clk       (i_pcie_clk),
        .rst       (i_rst),
        .inc_en    (tlp_accept_c),
        .inc_bytes (chunk_q),
        .dec_en    (cpl_match_c),
        .dec_bytes (CFG_REM_W'({i_cpl_len_dw, 2'b00})),
        .count     (o_outstanding),
        .err       (o_cpl_err)
    );

endmodule

// File: tb/tb_config_rd_req_splitter.sv
// Directed testbench for config_rd_req_splitter (MAX_RD_REQ=512, credit 1024 bytes).
module tb_config_rd_req_splitter;

    localparam int unsigned MAX_RD_REQ = 512;
    localparam int unsigned CPL_CREDIT = 1024;

    logic        i_pcie_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_rd_req = 1'b0;
    logic [31:0] i_rd_req_addr = '0;
    logic [11:0] i_rd_req_len = '0;
    logic [7:0]  i_rd_req_tag = '0;
    logic        o_rd_req_ack;
    logic        o_tlp_req;
    logic [31:0] o_tlp_addr;
    logic [9:0]  o_tlp_len_dw;
    logic [7:0]  o_tlp_tag;
    logic        i_tlp_ack = 1'b1;
    logic        i_cpl_valid = 1'b0;
    logic [7:0]  i_cpl_tag = '0;
    logic [2:0]  i_cpl_len_dw = '0;
    logic [12:0] o_outstanding;
    logic        o_cpl_err;

    int errors = 0;
    int checks = 0;

    int          owed = 0;
    logic [31:0] tlp_addrs[$];
    int          tlp_lens[$];
    int          acks;
    bit          timed_out;

    config_rd_req_splitter #(
        .MAX_RD_REQ       (MAX_RD_REQ),
        .CPL_CREDIT_BYTES (CPL_CREDIT)
    ) dut (
        .i_pcie_clk    (i_pcie_clk),
        .i_rst         (i_rst),
        .i_rd_req      (i_rd_req),
        .i_rd_req_addr (i_rd_req_addr),
        .i_rd_req_len  (i_rd_req_len),
        .i_rd_req_tag  (i_rd_req_tag),
        .o_rd_req_ack  (o_rd_req_ack),
        .o_tlp_req     (o_tlp_req),
        .o_tlp_addr    (o_tlp_addr),
        .o_tlp_len_dw  (o_tlp_len_dw),
        .o_tlp_tag     (o_tlp_tag),
        .i_tlp_ack     (i_tlp_ack),
        .i_cpl_valid   (i_cpl_valid),
        .i_cpl_tag     (i_cpl_tag),
        .i_cpl_len_dw  (i_cpl_len_dw),
        .o_outstanding (o_outstanding),
        .o_cpl_err     (o_cpl_err)
    );

    always #5 i_pcie_clk = ~i_pcie_clk;

    // Raise a level request with tag 0.
    task automatic start_req(input logic [31:0] a, input logic [11:0] l);
        @(negedge i_pcie_clk);
        i_rd_req      = 1'b1;
        i_rd_req_addr = a;
        i_rd_req_len  = l;
        i_rd_req_tag  = 8'h00;
    endtask

    // Run the handshake: record accepted TLPs, count ack pulses, optionally
    // return 2-DW completions for owed bytes. Bounded by max_cyc.
    task automatic pump(input bit ret_cpl, input bit drop_req, input int max_cyc);
        tlp_addrs.delete();
        tlp_lens.delete();
        acks      = 0;
        timed_out = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge i_pcie_clk);
            if (o_rd_req_ack) begin
                acks++;
                if (drop_req) i_rd_req = 1'b0;
            end
            i_cpl_valid = 1'b0;
            if (ret_cpl && owed >= 8) begin
                i_cpl_valid  = 1'b1;
                i_cpl_tag    = 8'h00;
                i_cpl_len_dw = 3'd2;
                owed -= 8;
            end
            if (o_tlp_req && i_tlp_ack) begin
                tlp_addrs.push_back(o_tlp_addr);
                tlp_lens.push_back(int'(o_tlp_len_dw));
                owed += int'(o_tlp_len_dw) * 4;
            end
            if (acks > 0 && (!ret_cpl || owed == 0)) begin
                timed_out = 1'b0;
                break;
            end
        end
        @(negedge i_pcie_clk);
        i_cpl_valid = 1'b0;
    endtask

    // Return a number of matching 2-DW completion beats.
    task automatic drain(input int beats);
        for (int b = 0; b < beats; b++) begin
            @(negedge i_pcie_clk);
            i_cpl_valid  = 1'b1;
            i_cpl_tag    = 8'h00;
            i_cpl_len_dw = 3'd2;
            owed -= 8;
        end
        @(negedge i_pcie_clk);
        i_cpl_valid = 1'b0;
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        repeat (3) @(negedge i_pcie_clk);
        checks++; if (o_tlp_req !== 1'b0) begin errors++; $display("FAIL reset_tlp_req: got %0b want 0", o_tlp_req); end
        checks++; if (o_rd_req_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %0b want 0", o_rd_req_ack); end
        checks++; if (o_tlp_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %0h want 0", o_tlp_addr); end
        checks++; if (o_tlp_len_dw !== 10'd0) begin errors++; $display("FAIL reset_len: got %0d want 0", o_tlp_len_dw); end
        checks++; if (o_outstanding !== 13'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", o_outstanding); end
        checks++; if (o_cpl_err !== 1'b0) begin errors++; $display("FAIL reset_cpl_err: got %0b want 0", o_cpl_err); end
        i_rst = 1'b0;
        @(negedge i_pcie_clk);
    endtask

    task automatic test_short_len;
        start_req(32'h0800_0000, 12'd3);
        pump(1'b0, 1'b1, 20);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL short_timeout: no ack within bound"); end
        checks++; if (tlp_addrs.size() != 0) begin errors++; $display("FAIL short_tlps: got %0d want 0", tlp_addrs.size()); end
        checks++; if (acks != 1) begin errors++; $display("FAIL short_acks: got %0d want 1", acks); end
    endtask

    task automatic test_aligned_full;
        start_req(32'h1000_0000, 12'h000);
        pump(1'b1, 1'b1, 3000);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL full_timeout: not finished within bound"); end
        checks++; if (tlp_addrs.size() != 8) begin errors++; $display("FAIL full_count: got %0d want 8", tlp_addrs.size()); end
        for (int i = 0; i < 8 && i < tlp_addrs.size(); i++) begin
            checks++;
            if (tlp_addrs[i] !== 32'h1000_0000 + 32'(i) * 32'h200) begin
                errors++; $display("FAIL full_addr[%0d]: got %0h want %0h", i, tlp_addrs[i], 32'h1000_0000 + 32'(i) * 32'h200);
            end
            checks++;
            if (tlp_lens[i] != 128) begin errors++; $display("FAIL full_len[%0d]: got %0d want 128", i, tlp_lens[i]); end
        end
        checks++; if (acks != 1) begin errors++; $display("FAIL full_acks: got %0d want 1", acks); end
        checks++; if (o_outstanding !== 13'd0) begin errors++; $display("FAIL full_outstanding: got %0d want 0", o_outstanding); end
    endtask

    task automatic test_unaligned;
        start_req(32'h1000_0F80, 12'h100);
        pump(1'b1, 1'b1, 500);
        checks++; if (tlp_addrs.size() != 2) begin errors++; $display("FAIL unal_count: got %0d want 2", tlp_addrs.size()); end
        if (tlp_addrs.size() == 2) begin
            checks++; if (tlp_addrs[0] !== 32'h1000_0F80) begin errors++; $display("FAIL unal_addr0: got %0h want 10000f80", tlp_addrs[0]); end
            checks++; if (tlp_lens[0] != 32) begin errors++; $display("FAIL unal_len0: got %0d want 32", tlp_lens[0]); end
            checks++; if (tlp_addrs[1] !== 32'h1000_1000) begin errors++; $display("FAIL unal_addr1: got %0h want 10001000", tlp_addrs[1]); end
            checks++; if (tlp_lens[1] != 32) begin errors++; $display("FAIL unal_len1: got %0d want 32", tlp_lens[1]); end
        end
        checks++; if (acks != 1) begin errors++; $display("FAIL unal_acks: got %0d want 1", acks); end
    endtask

    task automatic test_credit_stall;
        bit early;
        start_req(32'h2000_0000, 12'h000);
        pump(1'b0, 1'b1, 40);
        checks++; if (tlp_addrs.size() != 2) begin errors++; $display("FAIL stall_count: got %0d want 2", tlp_addrs.size()); end
        checks++; if (o_tlp_req !== 1'b0) begin errors++; $display("FAIL stall_req: got %0b want 0", o_tlp_req); end
        checks++; if (o_outstanding !== 13'd1024) begin errors++; $display("FAIL stall_outstanding: got %0d want 1024", o_outstanding); end
        early = 1'b0;
        for (int b = 0; b < 64; b++) begin
            @(negedge i_pcie_clk);
            if (o_tlp_req) early = 1'b1;
            i_cpl_valid  = 1'b1;
            i_cpl_tag    = 8'h00;
            i_cpl_len_dw = 3'd2;
            owed -= 8;
        end
        @(negedge i_pcie_clk);
        i_cpl_valid = 1'b0;
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL stall_early: got tlp_req before credit returned"); end
        pump(1'b1, 1'b1, 3000);
        checks++; if (tlp_addrs.size() != 6) begin errors++; $display("FAIL stall_rest_count: got %0d want 6", tlp_addrs.size()); end
        if (tlp_addrs.size() > 0) begin
            checks++; if (tlp_addrs[0] !== 32'h2000_0400) begin errors++; $display("FAIL stall_third_addr: got %0h want 20000400", tlp_addrs[0]); end
        end
        checks++; if (acks != 1) begin errors++; $display("FAIL stall_acks: got %0d want 1", acks); end
        checks++; if (o_outstanding !== 13'd0) begin errors++; $display("FAIL stall_final_out: got %0d want 0", o_outstanding); end
    endtask

    task automatic test_simultaneous;
        bit found;
        start_req(32'h3000_0100, 12'd8);
        pump(1'b0, 1'b1, 50);
        checks++; if (tlp_lens.size() != 1 || tlp_lens[0] != 2) begin errors++; $display("FAIL sim_pre_len: got %0d tlps want one of len 2", tlp_lens.size()); end
        checks++; if (o_outstanding !== 13'd8) begin errors++; $display("FAIL sim_pre_out: got %0d want 8", o_outstanding); end
        i_tlp_ack = 1'b0;
        start_req(32'h3000_0000, 12'h200);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge i_pcie_clk);
            if (o_tlp_req) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL sim_req_timeout: o_tlp_req not seen"); end
        @(negedge i_pcie_clk);
        checks++; if (o_tlp_req !== 1'b1 || o_tlp_addr !== 32'h3000_0000 || o_tlp_len_dw !== 10'd128) begin
            errors++; $display("FAIL sim_hold: got req=%0b addr=%0h len=%0d want 1 30000000 128", o_tlp_req, o_tlp_addr, o_tlp_len_dw);
        end
        i_tlp_ack    = 1'b1;
        i_cpl_valid  = 1'b1;
        i_cpl_tag    = 8'h00;
        i_cpl_len_dw = 3'd2;
        @(negedge i_pcie_clk);
        i_cpl_valid = 1'b0;
        owed = 512;
        checks++; if (o_outstanding !== 13'd512) begin errors++; $display("FAIL sim_net: got %0d want 512", o_outstanding); end
        checks++; if (o_rd_req_ack !== 1'b1) begin errors++; $display("FAIL sim_ack: got %0b want 1", o_rd_req_ack); end
        i_rd_req     = 1'b0;
        i_cpl_valid  = 1'b1;
        i_cpl_tag    = 8'h55;
        @(negedge i_pcie_clk);
        i_cpl_valid = 1'b0;
        i_cpl_tag   = 8'h00;
        checks++; if (o_outstanding !== 13'd512) begin errors++; $display("FAIL sim_foreign: got %0d want 512", o_outstanding); end
        drain(64);
        checks++; if (o_outstanding !== 13'd0) begin errors++; $display("FAIL sim_drain: got %0d want 0", o_outstanding); end
        checks++; if (o_cpl_err !== 1'b0) begin errors++; $display("FAIL sim_err: got %0b want 0", o_cpl_err); end
    endtask

    task automatic test_level_handshake;
        bit bad;
        start_req(32'h4000_0000, 12'h040);
        pump(1'b1, 1'b0, 300);
        checks++; if (tlp_lens.size() != 1 || tlp_lens[0] != 16) begin errors++; $display("FAIL lvl_first: got %0d tlps want one of len 16", tlp_lens.size()); end
        checks++; if (acks != 1) begin errors++; $display("FAIL lvl_first_ack: got %0d want 1", acks); end
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge i_pcie_clk);
            if (o_tlp_req || o_rd_req_ack) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL lvl_reaccept: activity while request held high"); end
        i_rd_req = 1'b0;
        start_req(32'h4000_0100, 12'd4);
        pump(1'b1, 1'b1, 100);
        checks++; if (tlp_addrs.size() != 1) begin errors++; $display("FAIL lvl_count: got %0d want 1", tlp_addrs.size()); end
        if (tlp_addrs.size() == 1) begin
            checks++; if (tlp_addrs[0] !== 32'h4000_0100 || tlp_lens[0] != 1) begin
                errors++; $display("FAIL lvl_dw1: got addr=%0h len=%0d want 40000100 1", tlp_addrs[0], tlp_lens[0]);
            end
        end
    endtask

    task automatic test_reset_mid_issue;
        bit found;
        bit busy;
        start_req(32'h5000_0000, 12'd8);
        pump(1'b0, 1'b1, 50);
        i_tlp_ack = 1'b0;
        start_req(32'h5000_0100, 12'h100);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge i_pcie_clk);
            if (o_tlp_req) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL rst_req_timeout: o_tlp_req not seen"); end
        i_rst    = 1'b1;
        i_rd_req = 1'b0;
        @(negedge i_pcie_clk);
        checks++; if (o_tlp_req !== 1'b0) begin errors++; $display("FAIL rst_mid_req: got %0b want 0", o_tlp_req); end
        checks++; if (o_outstanding !== 13'd0) begin errors++; $display("FAIL rst_mid_out: got %0d want 0", o_outstanding); end
        i_rst     = 1'b0;
        i_tlp_ack = 1'b1;
        owed      = 0;
        busy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_pcie_clk);
            if (o_tlp_req) busy = 1'b1;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle: tlp_req after reset"); end
        i_cpl_valid  = 1'b1;
        i_cpl_tag    = 8'h00;
        i_cpl_len_dw = 3'd2;
        @(negedge i_pcie_clk);
        i_cpl_valid = 1'b0;
        checks++; if (o_cpl_err !== 1'b1) begin errors++; $display("FAIL rst_cpl_err: got %0b want 1", o_cpl_err); end
        checks++; if (o_outstanding !== 13'd0) begin errors++; $display("FAIL rst_clamp: got %0d want 0", o_outstanding); end
    endtask

    initial begin
        test_reset();
        test_short_len();
        test_aligned_full();
        test_unaligned();
        test_credit_stall();
        test_simultaneous();
        test_level_handshake();
        test_reset_mid_issue();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
